// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic sequencers.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/fa_slice.sv
// One-bit full-adder cell: the only arithmetic in the serial adder.
module fa_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one fa_slice, LSB first, registered carry,
// registered sum/carry-out/overflow presented with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] MsbCnt  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  // Holds the WIDTH-1 most recent sum bits; the final bit joins them on the last edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             slice_s, slice_c;
  logic [WIDTH-1:0] shifted;

  fa_slice u_fa_slice (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  assign shifted = {slice_s, res_q};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d   = shifted[WIDTH-1:1];
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = slice_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == MsbCnt) begin
          cmsb_d = slice_c;
        end
        if (cnt_q == LastCnt) begin
          sum_d   = shifted;
          cout_d  = slice_c;
          ovf_d   = cmsb_q ^ slice_c;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised and directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=13,
// checked against an integer-arithmetic reference model.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;

  logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, sub13, cin13, busy13, done13, cout13, ovf13;
  logic [12:0] a13, b13, sum13;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] prev8 = '0;
  logic [63:0] prev13 = '0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .sub      (sub8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8)
  );

  serial_adder_ctrl #(.WIDTH(13)) u_dut13 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start13),
    .sub      (sub13),
    .a        (a13),
    .b        (b13),
    .cin      (cin13),
    .busy     (busy13),
    .done     (done13),
    .sum      (sum13),
    .cout     (cout13),
    .overflow (ovf13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Signed and unsigned integer view of the operation; no bit-level slicing.
  function automatic void model(input int w, input bit s, input logic [63:0] av,
                                input logic [63:0] bv, input bit c,
                                output logic [63:0] es, output bit ec, output bit eo);
    longint m, ua, ub, sa, sb, full, sr;
    m  = longint'(1) << w;
    ua = longint'(av);
    ub = longint'(bv);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      full = ua - ub + m;
      sr   = sa - sb;
    end else begin
      full = ua + ub + longint'(c);
      sr   = sa + sb + longint'(c);
    end
    es = 64'(full % m);
    ec = (full >= m);
    eo = (sr > m / 2 - 1) || (sr < -(m / 2));
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic drive(input int w, input bit st, input bit s, input logic [63:0] av,
                       input logic [63:0] bv, input bit c);
    if (w == 8) begin
      start8 = st; sub8 = s; a8 = av[7:0]; b8 = bv[7:0]; cin8 = c;
    end else begin
      start13 = st; sub13 = s; a13 = av[12:0]; b13 = bv[12:0]; cin13 = c;
    end
  endtask

  function automatic bit get_busy(input int w);
    return (w == 8) ? busy8 : busy13;
  endfunction

  function automatic bit get_done(input int w);
    return (w == 8) ? done8 : done13;
  endfunction

  function automatic logic [63:0] get_sum(input int w);
    return (w == 8) ? 64'(sum8) : 64'(sum13);
  endfunction

  function automatic bit get_cout(input int w);
    return (w == 8) ? cout8 : cout13;
  endfunction

  function automatic bit get_ovf(input int w);
    return (w == 8) ? ovf8 : ovf13;
  endfunction

  // Called at a negedge; returns at the negedge where done is high (or the bound expires).
  task automatic run_op(input int w, input bit s, input logic [63:0] av,
                        input logic [63:0] bv, input bit c);
    logic [63:0] es, prev;
    bit ec, eo, seen;
    int n, bc;
    model(w, s, av, bv, c, es, ec, eo);
    prev = (w == 8) ? prev8 : prev13;
    seen = 1'b0;
    bc = 0;
    drive(w, 1'b1, s, av, bv, c);
    @(negedge clk);
    drive(w, 1'b0, 1'($urandom), rnd(w), rnd(w), 1'($urandom));
    n = 1;
    for (int i = 0; i < 2 * w + 4; i++) begin
      if (get_done(w)) begin
        seen = 1'b1;
        break;
      end
      if (get_busy(w)) bc++;
      if (n == w) chk_eq("sum_hold", get_sum(w), prev);
      // Start pulses during RUN must be ignored.
      drive(w, 1'($urandom), 1'($urandom), rnd(w), rnd(w), 1'($urandom));
      @(negedge clk);
      drive(w, 1'b0, 1'b0, '0, '0, 1'b0);
      n++;
    end
    chk_eq("done_seen", 64'(seen), 64'd1);
    chk_eq("latency", 64'(n), 64'(w + 1));
    chk_eq("busy_cycles", 64'(bc), 64'(w));
    chk_eq("sum", get_sum(w), es);
    chk_eq("cout", 64'(get_cout(w)), 64'(ec));
    chk_eq("overflow", 64'(get_ovf(w)), 64'(eo));
    if (w == 8) prev8 = es; else prev13 = es;
  endtask

  logic [63:0] held_exp [4];
  logic [63:0] es_t;
  bit ec_t, eo_t;

  initial begin
    rst_n = 1'b0;
    drive(8, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(13, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    chk_eq("rst_busy", 64'(busy8), 64'd0);
    chk_eq("rst_done", 64'(done8), 64'd0);
    chk_eq("rst_sum", 64'(sum8), 64'd0);
    chk_eq("rst_cout", 64'(cout8), 64'd0);
    chk_eq("rst_ovf", 64'(ovf8), 64'd0);
    chk_eq("rst_sum13", 64'(sum13), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(8, 1'b0, 64'h3C, 64'h5A, 1'b0);
    run_op(8, 1'b0, 64'hFF, 64'h01, 1'b0);
    run_op(8, 1'b0, 64'h00, 64'h00, 1'b1);
    run_op(8, 1'b1, 64'h10, 64'h20, 1'b0);
    run_op(8, 1'b1, 64'h80, 64'h01, 1'b1);
    @(negedge clk);

    // Start held high: new ops accepted only from IDLE/DONE, every WIDTH+1 cycles.
    begin
      logic [63:0] av, bv;
      bit s, c;
      av = rnd(8); bv = rnd(8); s = 1'($urandom); c = 1'($urandom);
      model(8, s, av, bv, c, es_t, ec_t, eo_t);
      held_exp[0] = es_t;
      drive(8, 1'b1, s, av, bv, c);
      for (int j = 1; j <= 27; j++) begin
        @(negedge clk);
        if (j % 9 == 0) begin
          chk_eq("held_done", 64'(done8), 64'd1);
          chk_eq("held_sum", 64'(sum8), held_exp[j / 9 - 1]);
          prev8 = held_exp[j / 9 - 1];
        end else begin
          chk_eq("held_nodone", 64'(done8), 64'd0);
          chk_eq("held_stable", 64'(sum8), prev8);
        end
        av = rnd(8); bv = rnd(8); s = 1'($urandom); c = 1'($urandom);
        if (j == 27) begin
          drive(8, 1'b0, s, av, bv, c);
        end else begin
          drive(8, 1'b1, s, av, bv, c);
          if (j % 9 == 0) begin
            model(8, s, av, bv, c, es_t, ec_t, eo_t);
            held_exp[j / 9] = es_t;
          end
        end
      end
      @(negedge clk);
      chk_eq("held_idle", 64'(busy8), 64'd0);
    end

    // Reset in the middle of an operation that carries.
    drive(8, 1'b1, 1'b0, 64'hFF, 64'h01, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk_eq("pre_rst_busy", 64'(busy8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_busy", 64'(busy8), 64'd0);
    chk_eq("mid_rst_done", 64'(done8), 64'd0);
    chk_eq("mid_rst_sum", 64'(sum8), 64'd0);
    chk_eq("mid_rst_cout", 64'(cout8), 64'd0);
    chk_eq("mid_rst_ovf", 64'(ovf8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev8 = '0;
    prev13 = '0;
    @(negedge clk);
    run_op(8, 1'b0, 64'h01, 64'h01, 1'b0);

    // Randomised operations at both widths.
    for (int i = 0; i < 1000; i++) begin
      run_op(8, 1'($urandom), rnd(8), rnd(8), 1'($urandom));
      if ($urandom_range(3) == 0) @(negedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      run_op(13, 1'($urandom), rnd(13), rnd(13), 1'($urandom));
      if ($urandom_range(3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
